data_mem_responder: RTL and testbench

Memory-side responder for the load/store control path: accepts a request qualified by mem_read/mem_write plus funct3, address and store data. It performs RV64 byte/half/word/double accesses on an internal 64-bit-wide array after a fixed latency. It returns load data sign- or zero-extended, or an error flag, over a valid/ready response handshake. It sits between the execute-stage address generator and writeback (mem_to_reg path).

---
 rtl/data_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: RV64 loads/stores on a 64-bit word array,
// fixed request-to-response latency, valid/ready response handshake.
module data_mem_responder #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] rdata,
    output logic            err
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, wr_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   addr_q, wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;
    logic              latch, commit;

    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

    // With LATENCY=1 the access happens on the accept edge, so use live inputs in IDLE.
    logic              op_rd, op_wr;
    logic [2:0]        op_f3;
    logic [XLEN-1:0]   op_addr, op_wdata;

    always_comb begin
        if (state_q == StIdle) begin
            op_rd    = mem_read;
            op_wr    = mem_write;
            op_f3    = funct3;
            op_addr  = addr;
            op_wdata = wdata;
        end else begin
            op_rd    = rd_q;
            op_wr    = wr_q;
            op_f3    = f3_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
    end

    logic [IDX_W-1:0]  idx;
    logic [2:0]        lane;
    logic [5:0]        sh;
    logic              misalign, illegal, out_of_range, op_err;
    logic [XLEN-1:0]   word, ld_sh, ld_val, wr_sh, wr_mask, merged;
    logic [7:0]        be_base, be;

    assign idx          = op_addr[IDX_W+2:3];
    assign lane         = op_addr[2:0];
    assign sh           = {lane, 3'b000};
    assign out_of_range = |op_addr[XLEN-1:IDX_W+3];
    assign word         = mem_q[idx];
    assign ld_sh        = word >> sh;
    assign wr_sh        = op_wdata << sh;

    always_comb begin
        misalign = 1'b0;
        be_base  = 8'h00;
        unique case (op_f3[1:0])
            2'b00: begin misalign = 1'b0;          be_base = 8'h01; end
            2'b01: begin misalign = op_addr[0];    be_base = 8'h03; end
            2'b10: begin misalign = |op_addr[1:0]; be_base = 8'h0F; end
            2'b11: begin misalign = |op_addr[2:0]; be_base = 8'hFF; end
            default: ;
        endcase
        illegal = (op_rd && op_wr) || (op_rd && op_f3 == 3'b111) || (op_wr && op_f3[2]);
        op_err  = illegal || misalign || out_of_range;
        be      = be_base << lane;
        wr_mask = '0;
        for (int b = 0; b < 8; b++) begin
            wr_mask[b*8 +: 8] = {8{be[b]}};
        end
        merged = (word & ~wr_mask) | (wr_sh & wr_mask);
    end

    always_comb begin
        ld_val = '0;
        unique case (op_f3)
            3'b000:  ld_val = {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_val = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
            3'b010:  ld_val = {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
            3'b011:  ld_val = ld_sh;
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_sh[7:0]};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_sh[15:0]};
            3'b110:  ld_val = {{(XLEN-32){1'b0}}, ld_sh[31:0]};
            default: ld_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Requests with neither read nor write are silently dropped.
                if (req_valid && (mem_read || mem_write)) begin
                    latch = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        req_ready  = (state_q == StIdle) && !rst;
        resp_valid = (state_q == StResp);
        rdata      = rdata_q;
        err        = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                rd_q    <= mem_read;
                wr_q    <= mem_write;
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (commit) begin
                rdata_q <= (op_rd && !op_err) ? ld_val : '0;
                err_q   <= op_err;
            end
        end
    end

    // Array is not reset; a reset in the commit cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_wr && !op_err) begin
            mem_q[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (XLEN=64, DEPTH_WORDS=512, LATENCY=2).
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [63:0] addr, wdata, rdata;
    logic        resp_valid, resp_ready, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .XLEN        (64),
        .DEPTH_WORDS (512),
        .LATENCY     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .rdata      (rdata),
        .err        (err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, check latency/result, optionally stall the response, then complete it.
    task automatic run_txn(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] exp_rdata, input logic exp_err, input int hold);
        int n;
        @(negedge clk);
        check_eq({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        // Scramble inputs after accept; the DUT must use its latched copy.
        req_valid = 1'b0; mem_read = ~rd; mem_write = ~wr; funct3 = ~f3;
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, ".latency"}, 64'(n), 64'd2);
        check_eq({tag, ".rdata"}, rdata, exp_rdata);
        check_eq({tag, ".err"}, 64'(err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011; addr = 64'h10;
            @(posedge clk); #1;
            check_eq({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
            check_eq({tag, ".hold_rdata"}, rdata, exp_rdata);
            check_eq({tag, ".hold_err"}, 64'(err), 64'(exp_err));
            check_eq({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_eq({tag, ".done_valid"}, 64'(resp_valid), 64'd0);
        check_eq({tag, ".done_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        addr = '0; wdata = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.req_ready", 64'(req_ready), 64'd0);
        check_eq("reset.resp_valid", 64'(resp_valid), 64'd0);
        check_eq("reset.rdata", rdata, 64'd0);
        check_eq("reset.err", 64'(err), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle.req_ready", 64'(req_ready), 64'd1);

        // No-op request: nothing happens.
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("noop.resp_valid", 64'(resp_valid), 64'd0);
        check_eq("noop.req_ready", 64'(req_ready), 64'd1);

        run_txn("sd10", 1'b0, 1'b1, 3'b011, 64'h10, 64'h8877665544332211, 64'h0, 1'b0, 0);
        run_txn("ld10", 1'b1, 1'b0, 3'b011, 64'h10, 64'h0, 64'h8877665544332211, 1'b0, 0);
        run_txn("lb17", 1'b1, 1'b0, 3'b000, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 0);
        run_txn("lbu17", 1'b1, 1'b0, 3'b100, 64'h17, 64'h0, 64'h0000000000000088, 1'b0, 0);
        run_txn("lh12", 1'b1, 1'b0, 3'b001, 64'h12, 64'h0, 64'h0000000000004433, 1'b0, 0);
        run_txn("lwu14", 1'b1, 1'b0, 3'b110, 64'h14, 64'h0, 64'h0000000088776655, 1'b0, 0);
        run_txn("lw14", 1'b1, 1'b0, 3'b010, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 1'b0, 0);

        run_txn("sb11", 1'b0, 1'b1, 3'b000, 64'h11, 64'h123456789ABCDEAB, 64'h0, 1'b0, 0);
        run_txn("ld10_sb", 1'b1, 1'b0, 3'b011, 64'h10, 64'h0, 64'h887766554433AB11, 1'b0, 0);

        run_txn("lw12_mis", 1'b1, 1'b0, 3'b010, 64'h12, 64'h0, 64'h0, 1'b1, 0);
        run_txn("sd1004", 1'b0, 1'b1, 3'b011, 64'h1004, 64'hDEAD, 64'h0, 1'b1, 0);
        run_txn("sd1000_oor", 1'b0, 1'b1, 3'b011, 64'h1000, 64'hDEAD, 64'h0, 1'b1, 0);
        run_txn("ld1000_oor", 1'b1, 1'b0, 3'b011, 64'h1000, 64'h0, 64'h0, 1'b1, 0);
        run_txn("rdwr", 1'b1, 1'b1, 3'b011, 64'h10, 64'h0, 64'h0, 1'b1, 0);
        run_txn("ld_f3_111", 1'b1, 1'b0, 3'b111, 64'h10, 64'h0, 64'h0, 1'b1, 0);
        run_txn("sd_f3_100", 1'b0, 1'b1, 3'b100, 64'h10, 64'h0, 64'h0, 1'b1, 0);
        run_txn("ld10_after_err", 1'b1, 1'b0, 3'b011, 64'h10, 64'h0, 64'h887766554433AB11, 1'b0, 0);

        run_txn("sw14", 1'b0, 1'b1, 3'b010, 64'h14, 64'hFFFFFFFFDEADBEEF, 64'h0, 1'b0, 0);
        run_txn("ld10_sw", 1'b1, 1'b0, 3'b011, 64'h10, 64'h0, 64'hDEADBEEF4433AB11, 1'b0, 0);
        run_txn("lh16", 1'b1, 1'b0, 3'b001, 64'h16, 64'h0, 64'hFFFFFFFFFFFFDEAD, 1'b0, 0);

        // Stall response for 5 cycles with a competing request present.
        run_txn("stall", 1'b1, 1'b0, 3'b011, 64'h10, 64'h0, 64'hDEADBEEF4433AB11, 1'b0, 5);
        repeat (3) @(posedge clk);
        #1;
        check_eq("stall.no_accept", 64'(resp_valid), 64'd0);

        // Reset in WAIT must discard a pending store.
        run_txn("sd20_5", 1'b0, 1'b1, 3'b011, 64'h20, 64'h5, 64'h0, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b011;
        addr = 64'h20; wdata = 64'h1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rstwait.resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rstwait.req_ready", 64'(req_ready), 64'd0);
        check_eq("rstwait.rdata", rdata, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rstwait.resp_valid2", 64'(resp_valid), 64'd0);
        check_eq("rstwait.idle_ready", 64'(req_ready), 64'd1);
        run_txn("ld20", 1'b1, 1'b0, 3'b011, 64'h20, 64'h0, 64'h5, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
